// File: rtl/fetch_unit.sv
// Instruction fetch stage: a single-outstanding-request memory FSM feeding a small
// prefetch queue, drained into a registered pc/instruction/valid output stage.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  localparam logic [2:0] DEPTH    = 3'(QUEUE_DEPTH);
  localparam logic [1:0] PTR_LAST = 2'(QUEUE_DEPTH - 1);

  state_t      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] inflight_q, inflight_d;
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic [31:0] pc_q, instr_q;
  logic        valid_q;

  // Storage sized for the largest legal depth so pointers index it without width games.
  logic [31:0] q_pc    [4];
  logic [31:0] q_instr [4];

  logic       pop, push, space, space_after_push;
  logic [2:0] count_after_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign pop              = !branch_taken && !freeze && (count_q != 3'd0);
  assign push             = (state_q == REQ) && imem_ready && !branch_taken;
  assign count_after_pop  = count_q - {2'b00, pop};
  assign space            = count_after_pop < DEPTH;
  assign space_after_push = (count_after_pop + 3'd1) < DEPTH;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    inflight_d   = inflight_q;
    if (branch_taken) fetch_addr_d = branch_addr;
    case (state_q)
      IDLE: if (space && !branch_taken) state_d = REQ;
      REQ: begin
        if (imem_ready) begin
          if (branch_taken) begin
            state_d = IDLE;
          end else begin
            fetch_addr_d = fetch_addr_q + 32'd4;
            state_d      = space_after_push ? REQ : IDLE;
          end
        end else if (branch_taken) begin
          // The old request is still on the bus; keep its address until it completes.
          state_d    = DISCARD;
          inflight_d = fetch_addr_q;
        end
      end
      DISCARD: if (imem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (branch_taken) count_d = 3'd0;
    else              count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr_q]    <= fetch_addr_q + 32'd4;
      q_instr[wr_ptr_q] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      inflight_q   <= RESET_PC;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      pc_q         <= 32'h0;
      instr_q      <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      imem_req_q   <= (state_d != IDLE);
      imem_addr_q  <= (state_d == DISCARD) ? inflight_d : fetch_addr_d;
      if (branch_taken) begin
        wr_ptr_q <= 2'd0;
        rd_ptr_q <= 2'd0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (branch_taken || (!freeze && count_q == 3'd0)) begin
        pc_q    <= 32'h0;
        instr_q <= 32'h0;
        valid_q <= 1'b0;
      end else if (pop) begin
        pc_q    <= q_pc[rd_ptr_q];
        instr_q <= q_instr[rd_ptr_q];
        valid_q <= 1'b1;
      end
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus an async-reset sequence.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, branch_taken, imem_ready;
  logic [31:0] branch_addr;
  logic        imem_req, valid;
  logic [31:0] imem_addr, imem_rdata, pc, instruction;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory model: each word is its address xor a key, so the bench can predict instructions.
  assign imem_rdata = imem_addr ^ KEY;

  fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc),
    .instruction(instruction), .valid(valid)
  );

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vec [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc);
    logic [31:0] e_instr;
    e_instr = e_valid ? ((e_pc - 32'd4) ^ KEY) : 32'h0;
    chk({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, e_req});
    if (e_req) chk({tag, " imem_addr"}, imem_addr, e_addr);
    chk({tag, " valid"}, {31'h0, valid}, {31'h0, e_valid});
    chk({tag, " pc"}, pc, e_valid ? e_pc : 32'h0);
    chk({tag, " instruction"}, instruction, e_instr);
    $display("%s: req=%0b addr=%h valid=%0b pc=%h instr=%h", tag, imem_req, imem_addr,
             valid, pc, instruction);
  endtask

  initial begin
    //            frz br baddr          rdy  req addr           valid pc
    vec[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    vec[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, 32'h0};
    vec[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h4};
    vec[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b1, 32'h8};
    vec[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8};
    vec[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8};
    vec[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8};
    vec[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b1, 32'hC};
    vec[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14,        1'b1, 32'h10};
    vec[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h18,        1'b1, 32'h14};
    vec[10] = '{1'b0, 1'b1, 32'h100,       1'b0, 1'b1, 32'h18,        1'b0, 32'h0};
    vec[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h18,        1'b0, 32'h0};
    vec[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    vec[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       1'b0, 32'h0};
    vec[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104,       1'b0, 32'h0};
    vec[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h108,       1'b1, 32'h104};
    vec[16] = '{1'b1, 1'b1, 32'h200,       1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    vec[17] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200,       1'b0, 32'h0};
    vec[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h204,       1'b0, 32'h0};
    vec[19] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h208,       1'b1, 32'h204};
    vec[20] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    vec[21] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vec[22] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    vec[23] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 32'h0};
    vec[24] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h4};

    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; imem_ready = 1'b1;
    #12;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    #10 rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      freeze       = vec[i].frz;
      branch_taken = vec[i].br;
      branch_addr  = vec[i].baddr;
      imem_ready   = vec[i].rdy;
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vec[i].e_req, vec[i].e_addr, vec[i].e_valid, vec[i].e_pc);
    end

    // Stall the memory so a request is outstanding, then reset between clock edges.
    freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    @(posedge clk); #1;
    chk_out("stall", 1'b1, 32'h8, 1'b1, 32'h8);
    #3 rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    chk_out("in_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk_out("post_rst0", 1'b1, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk_out("post_rst1", 1'b1, 32'h4, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk_out("post_rst2", 1'b1, 32'h8, 1'b1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
